mems_spi_dac_master: RTL and testbench
======================================

Name: mems_spi_dac_master

Overview:
- 24-bit write-only SPI master for the quad-channel MEMS drive DAC.
- Sits directly downstream of the MEMS channel sequencer. It consumes the sequencer's one-cycle start pulse and 24-bit command word, and returns the busy flag the sequencer polls.
- It serialises each word MSB-first onto SYNC/SCLK/DIN, then enforces a minimum SYNC-high gap before the next frame.

Parameters:
- CLK_DIV, 2: clk cycles per SCLK half-period. Legal values are ≥1.
- GAP_CYCLES, 2: clk cycles that SYNC is held high after a frame, with busy still high. Legal values are ≥1.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle request to send data_in; honoured only in IDLE.
- data_in  in  24  command word; captured on the edge that accepts start.
- busy  out  1  high from acceptance of start until the frame and gap are complete.
- done  out  1  one-cycle pulse when busy falls.
- sync_n  out  1  DAC frame select, active-low.
- sclk  out  1  serial clock; idles high.
- mosi  out  1  serial data to the DAC.

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, sync_n=1, sclk=1, mosi=0, shift register=0, counters=0.
- Reset is honoured mid-frame. At the next edge all outputs return to their reset values and the frame is aborted (SYNC rises immediately).
- All outputs are registered. There are no combinational paths from inputs to outputs.
- State machine: IDLE → SETUP → SHIFT_LO ↔ SHIFT_HI → GAP → IDLE.
- IDLE:
  - busy=0.
  - On an edge with start=1: latch data_in, set bit_cnt=23, set busy=1, set sync_n=0, drive mosi=data_in[23], go to SETUP.
  - busy is therefore already high in the cycle after the sequencer's start pulse.
- SETUP:
  - Hold sclk=1 for CLK_DIV cycles (SYNC-to-SCLK setup time), then go to SHIFT_LO.
- SHIFT_LO:
  - Drive sclk=0 for CLK_DIV cycles. The DAC samples mosi on this falling edge.
  - Then go to SHIFT_HI.
- SHIFT_HI:
  - Drive sclk=1 for CLK_DIV cycles.
  - If bit_cnt≠0, on the rising-SCLK edge: shift left, drive mosi=next bit, decrement bit_cnt.
  - At the end of the phase: if bit_cnt was 0, go to GAP; otherwise go to SHIFT_LO.
- GAP:
  - sync_n=1, mosi=0, sclk=1, busy=1 for GAP_CYCLES cycles.
  - Then go to IDLE with busy=0 and done=1 for one cycle.
- Total busy duration: CLK_DIV + 48·CLK_DIV + GAP_CYCLES cycles. For the defaults this is 100 cycles.
- Exactly 24 SCLK falling edges occur per frame. No SCLK edges occur while sync_n=1.
- start while busy=1 is ignored; it is neither queued nor an error.
- start in the cycle done is asserted (first IDLE cycle) is accepted normally, which gives back-to-back frames.
- data_in changes while busy have no effect on the frame in progress.
- Counter widths: half-period counter = $clog2(CLK_DIV+1); gap counter = $clog2(GAP_CYCLES+1); bit_cnt = 5 bits. No wrap-around is permitted.

Optional Feature:
MEMS_SPI_READBACK_EN
- Defined:
  - Adds input port miso (1 bit) and output port rx_data (24 bits, reset value 0).
  - miso is sampled at the end of each SHIFT_LO phase, MSB-first, into an rx shift register.
  - rx_data is loaded on the same edge that asserts done.
  - rx_data holds its value until the next completed frame. An aborted frame (rst) clears rx_data to 0.
- Undefined:
  - Neither port exists and no rx logic is synthesised.
  - All other behaviour is identical.

Test Plan:
- Reset, then idle 10 cycles → busy=0, done=0, sync_n=1, sclk=1, mosi=0 throughout.
- CLK_DIV=2, GAP_CYCLES=2; pulse start with data_in=24'h280001 →
  - busy high for exactly 100 cycles;
  - sync_n low for 98 cycles;
  - 24 sclk falling edges;
  - bits captured at the falling edges equal 24'h280001 MSB-first;
  - done pulses once as busy falls.
- Drive the sequencer-style handshake (start registered, next start only when !busy) with words 24'h1800xx, 24'h1900xx, 24'h1A00xx, 24'h1B00xx → four frames in order; each SYNC-high gap ≥2 cycles; no frame lost.
- Pulse start at cycle 30 of an active frame with data_in=24'hFFFFFF → ignored; the current frame completes unchanged and no second frame follows.
- Assert rst at bit 10 of a frame → next edge sync_n=1, sclk=1, busy=0, done=0; a subsequent start sends a complete, correct frame.
- With MEMS_SPI_READBACK_EN defined, loop miso=mosi and send 24'hA5C33C → rx_data=24'hA5C33C on the done edge.

Source files
------------

// File: rtl/mems_spi_dac_master_if.sv
// Bundle of the sequencer handshake and DAC serial lines for mems_spi_dac_master.
// Optional readback lines (miso, rx_data) exist only when MEMS_SPI_READBACK_EN is defined.
interface mems_spi_dac_master_if;
  logic        start;
  logic [23:0] data_in;
  logic        busy;
  logic        done;
  logic        sync_n;
  logic        sclk;
  logic        mosi;
`ifdef MEMS_SPI_READBACK_EN
  logic        miso;
  logic [23:0] rx_data;

  modport master (
    input  start, data_in, miso,
    output busy, done, sync_n, sclk, mosi, rx_data
  );

  modport slave (
    output start, data_in, miso,
    input  busy, done, sync_n, sclk, mosi, rx_data
  );
`else
  modport master (
    input  start, data_in,
    output busy, done, sync_n, sclk, mosi
  );

  modport slave (
    output start, data_in,
    input  busy, done, sync_n, sclk, mosi
  );
`endif
endinterface

// File: rtl/mems_spi_dac_master.sv
// 24-bit write-only SPI master for the quad-channel MEMS drive DAC.
// Frame: SYNC low, CLK_DIV-cycle setup, 24 SCLK periods (DAC samples on the
// falling edge, data advances on the rising edge), then GAP_CYCLES of SYNC high.
// Optional feature macro: MEMS_SPI_READBACK_EN (adds miso sampling and rx_data).
module mems_spi_dac_master #(
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  mems_spi_dac_master_if.master bus
);

  localparam int HALF_W = $clog2(CLK_DIV + 1);
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_LO,
    SHIFT_HI,
    GAP
  } state_t;

  state_t            state_reg, state_next;
  logic [HALF_W-1:0] half_cnt_reg, half_cnt_next;
  logic [GAP_W-1:0]  gap_cnt_reg, gap_cnt_next;
  logic [4:0]        bit_cnt_reg, bit_cnt_next;
  // Holds the bits still to be sent after the one currently on mosi.
  logic [22:0]       sr_reg, sr_next;
  // Set when the bit just sampled by the DAC was bit 0, so the HI phase ends the frame.
  logic              last_reg, last_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              sync_n_reg, sync_n_next;
  logic              sclk_reg, sclk_next;
  logic              mosi_reg, mosi_next;
`ifdef MEMS_SPI_READBACK_EN
  logic [23:0]       rx_sr_reg, rx_sr_next;
  logic [23:0]       rx_data_reg, rx_data_next;
`endif

  // State and output registers; reset also aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      half_cnt_reg <= '0;
      gap_cnt_reg  <= '0;
      bit_cnt_reg  <= '0;
      sr_reg       <= '0;
      last_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      sync_n_reg   <= 1'b1;
      sclk_reg     <= 1'b1;
      mosi_reg     <= 1'b0;
`ifdef MEMS_SPI_READBACK_EN
      rx_sr_reg    <= '0;
      rx_data_reg  <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      half_cnt_reg <= half_cnt_next;
      gap_cnt_reg  <= gap_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      sr_reg       <= sr_next;
      last_reg     <= last_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      sync_n_reg   <= sync_n_next;
      sclk_reg     <= sclk_next;
      mosi_reg     <= mosi_next;
`ifdef MEMS_SPI_READBACK_EN
      rx_sr_reg    <= rx_sr_next;
      rx_data_reg  <= rx_data_next;
`endif
    end
  end

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_next    = state_reg;
    half_cnt_next = half_cnt_reg;
    gap_cnt_next  = gap_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    sr_next       = sr_reg;
    last_next     = last_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    sync_n_next   = sync_n_reg;
    sclk_next     = sclk_reg;
    mosi_next     = mosi_reg;
`ifdef MEMS_SPI_READBACK_EN
    rx_sr_next    = rx_sr_reg;
    rx_data_next  = rx_data_reg;
`endif

    case (state_reg)
      IDLE: begin
        busy_next = 1'b0;
        if (bus.start) begin
          sr_next       = bus.data_in[22:0];
          mosi_next     = bus.data_in[23];
          bit_cnt_next  = 5'd23;
          last_next     = 1'b0;
          busy_next     = 1'b1;
          sync_n_next   = 1'b0;
          half_cnt_next = '0;
          state_next    = SETUP;
        end
      end

      SETUP: begin
        if (half_cnt_reg == HALF_LAST) begin
          half_cnt_next = '0;
          sclk_next     = 1'b0;
          state_next    = SHIFT_LO;
        end else begin
          half_cnt_next = half_cnt_reg + 1'b1;
        end
      end

      SHIFT_LO: begin
        if (half_cnt_reg == HALF_LAST) begin
          half_cnt_next = '0;
          sclk_next     = 1'b1;
          state_next    = SHIFT_HI;
`ifdef MEMS_SPI_READBACK_EN
          rx_sr_next    = {rx_sr_reg[22:0], bus.miso};
`endif
          if (bit_cnt_reg != 5'd0) begin
            mosi_next    = sr_reg[22];
            sr_next      = {sr_reg[21:0], 1'b0};
            bit_cnt_next = bit_cnt_reg - 5'd1;
          end else begin
            last_next    = 1'b1;
          end
        end else begin
          half_cnt_next = half_cnt_reg + 1'b1;
        end
      end

      SHIFT_HI: begin
        if (half_cnt_reg == HALF_LAST) begin
          half_cnt_next = '0;
          if (last_reg) begin
            sync_n_next  = 1'b1;
            mosi_next    = 1'b0;
            gap_cnt_next = '0;
            state_next   = GAP;
          end else begin
            sclk_next    = 1'b0;
            state_next   = SHIFT_LO;
          end
        end else begin
          half_cnt_next = half_cnt_reg + 1'b1;
        end
      end

      GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          gap_cnt_next = '0;
          busy_next    = 1'b0;
          done_next    = 1'b1;
          state_next   = IDLE;
`ifdef MEMS_SPI_READBACK_EN
          rx_data_next = rx_sr_reg;
`endif
        end else begin
          gap_cnt_next = gap_cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.busy   = busy_reg;
  assign bus.done   = done_reg;
  assign bus.sync_n = sync_n_reg;
  assign bus.sclk   = sclk_reg;
  assign bus.mosi   = mosi_reg;
`ifdef MEMS_SPI_READBACK_EN
  assign bus.rx_data = rx_data_reg;
`endif

endmodule

// File: tb/tb_mems_spi_dac_master.sv
// Self-checking bench for mems_spi_dac_master: a cycle-offset waveform model of
// each frame is compared against the DUT on every cycle, plus frame-level checks.
module tb_mems_spi_dac_master;

  localparam int CD    = 2;
  localparam int GC    = 2;
  localparam int TOTAL = CD + 48 * CD + GC;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mems_spi_dac_master_if bus ();

  mems_spi_dac_master #(.CLK_DIV(CD), .GAP_CYCLES(GC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef MEMS_SPI_READBACK_EN
  assign bus.miso = bus.mosi;
`endif

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: k = cycles since acceptance (0 = not busy).
  int          m_k = 0;
  logic [23:0] m_word = '0;
  logic        m_done = 1'b0;
  logic [23:0] m_rx = '0;
  logic [23:0] exp_q[$];

  always @(posedge clk) begin
    if (rst) begin
      m_k = 0; m_done = 1'b0; m_rx = '0;
    end else if (m_k == 0) begin
      m_done = 1'b0;
      if (bus.start) begin
        m_k = 1; m_word = bus.data_in; exp_q.push_back(bus.data_in);
      end
    end else if (m_k == TOTAL) begin
      m_k = 0; m_done = 1'b1; m_rx = m_word;
    end else begin
      m_k++;
    end
  end

  function automatic logic [3:0] exp_lines(input int k, input logic [23:0] w);
    int t, p, j;
    logic low;
    if (k == 0) return 4'b0110;                     // busy, sync_n, sclk, mosi
    t = k - 1;
    if (t < CD) return {1'b1, 1'b0, 1'b1, w[23]};
    if (t < CD + 48 * CD) begin
      p = t - CD;
      j = p / (2 * CD);
      low = (p % (2 * CD)) < CD;
      if (low) return {1'b1, 1'b0, 1'b0, w[23-j]};
      return {1'b1, 1'b0, 1'b1, (j < 23) ? w[22-j] : w[0]};
    end
    return 4'b1110;
  endfunction

  // Monitor/compare process: per-cycle model comparison and frame statistics.
  bit          armed = 1'b0;
  logic        prev_sclk = 1'b1, prev_sync = 1'b1;
  int          busy_cnt, sync_lo_cnt, fall_cnt, done_cnt, idle_edges, high_run;
  bit          had_frame = 1'b0;
  logic [23:0] cap = '0;
  logic [23:0] cap_q[$];

  always @(negedge clk) begin
    logic [3:0] e;
    if (armed) begin
      e = exp_lines(m_k, m_word);
      check("outputs{busy,done,sync_n,sclk,mosi}",
            {27'd0, bus.busy, bus.done, bus.sync_n, bus.sclk, bus.mosi},
            {27'd0, e[3], m_done, e[2], e[1], e[0]});
`ifdef MEMS_SPI_READBACK_EN
      check("rx_data", {8'd0, bus.rx_data}, {8'd0, m_rx});
`endif
      if (bus.busy) busy_cnt++;
      if (!bus.sync_n) sync_lo_cnt++;
      if (bus.done) done_cnt++;
      if (prev_sclk != bus.sclk && bus.sync_n) idle_edges++;
      if (prev_sclk && !bus.sclk) begin
        fall_cnt++;
        cap = {cap[22:0], bus.mosi};
      end
      if (prev_sync && !bus.sync_n) begin
        if (had_frame) check("sync_gap_ge_2", {31'd0, high_run >= GC}, 32'd1);
        had_frame = 1'b1;
        cap = '0;
      end
      if (!prev_sync && bus.sync_n) begin
        cap_q.push_back(cap);
        high_run = 0;
      end
      if (bus.sync_n) high_run++;
    end
    prev_sclk = bus.sclk;
    prev_sync = bus.sync_n;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_stats();
    busy_cnt = 0; sync_lo_cnt = 0; fall_cnt = 0; done_cnt = 0;
    cap_q.delete(); exp_q.delete();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && bus.busy; i++) tick();
    check("idle_timeout", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic send(input logic [23:0] w);
    for (int i = 0; i < 400 && bus.busy; i++) tick();
    check("send_wait_timeout", {31'd0, bus.busy}, 32'd0);
    bus.start = 1'b1;
    bus.data_in = w;
    tick();
    bus.start = 1'b0;
    bus.data_in = 24'($urandom);
  endtask

  task automatic check_frames(input string name);
    check({name, "_count"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
      check({name, "_word"}, {8'd0, cap_q[i]}, {8'd0, exp_q[i]});
  endtask

  initial begin
    logic [23:0] w;
    logic [23:0] seq_words [4];
    bus.start = 1'b0;
    bus.data_in = '0;
    high_run = 0; idle_edges = 0;
    clear_stats();

    // Reset and idle
    repeat (3) tick();
    check("reset_state", {27'd0, bus.busy, bus.done, bus.sync_n, bus.sclk, bus.mosi}, 32'b00110);
    armed = 1'b1;
    rst = 1'b0;
    repeat (10) tick();
    $display("idle: busy=%0b sync_n=%0b sclk=%0b", bus.busy, bus.sync_n, bus.sclk);

    // Single frame 24'h280001
    clear_stats();
    send(24'h280001);
    wait_idle();
    tick();
    check("busy_cycles", busy_cnt, 32'd100);
    check("sync_low_cycles", sync_lo_cnt, 32'd98);
    check("sclk_falls", fall_cnt, 32'd24);
    check("cap_size", cap_q.size(), 32'd1);
    if (cap_q.size() > 0) check("cap_280001", {8'd0, cap_q[0]}, 32'h00280001);
    check("done_pulses", done_cnt, 32'd1);
    $display("frame 280001: busy=%0d sync_lo=%0d falls=%0d", busy_cnt, sync_lo_cnt, fall_cnt);

    // Sequencer-style handshake, back-to-back
    clear_stats();
    for (int i = 0; i < 4; i++) begin
      seq_words[i] = {8'h18 + 8'(i), 8'h00, 8'($urandom)};
      send(seq_words[i]);
    end
    wait_idle();
    tick();
    check("seq_count", cap_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < cap_q.size(); i++) begin
      check("seq_word", {8'd0, cap_q[i]}, {8'd0, seq_words[i]});
      $display("seq frame %0d: sent %h got %h", i, seq_words[i], cap_q[i]);
    end
    check("seq_done", done_cnt, 32'd4);

    // start during busy is ignored
    clear_stats();
    w = 24'($urandom);
    send(w);
    repeat (29) tick();
    bus.start = 1'b1;
    bus.data_in = 24'hFFFFFF;
    tick();
    bus.start = 1'b0;
    wait_idle();
    repeat (10) tick();
    check("ignore_count", cap_q.size(), 32'd1);
    if (cap_q.size() > 0) check("ignore_word", {8'd0, cap_q[0]}, {8'd0, w});
    check("ignore_busy", busy_cnt, 32'd100);
    $display("ignored start: frame %h", w);

    // Reset at bit 10
    clear_stats();
    send(24'($urandom));
    repeat (CD + 10 * 2 * CD - 1) tick();
    rst = 1'b1;
    tick();
    check("abort_state", {27'd0, bus.busy, bus.done, bus.sync_n, bus.sclk, bus.mosi}, 32'b00110);
    rst = 1'b0;
    tick();
    clear_stats();
    w = 24'($urandom);
    send(w);
    wait_idle();
    tick();
    check("after_abort_count", cap_q.size(), 32'd1);
    if (cap_q.size() > 0) check("after_abort_word", {8'd0, cap_q[0]}, {8'd0, w});
    $display("after abort: sent %h", w);

`ifdef MEMS_SPI_READBACK_EN
    clear_stats();
    send(24'hA5C33C);
    wait_idle();
    tick();
    check("rx_A5C33C", {8'd0, bus.rx_data}, 32'h00A5C33C);
    $display("readback: rx_data=%h", bus.rx_data);
`endif

    // Random traffic with noise on start/data_in while busy
    clear_stats();
    for (int n = 0; n < 6; n++) begin
      repeat ($urandom_range(0, 5)) tick();
      send(24'($urandom));
      for (int i = 0; i < 400; i++) begin
        tick();
        if (!bus.busy) break;
        bus.start = ($urandom_range(0, 7) == 0);
        bus.data_in = 24'($urandom);
      end
      bus.start = 1'b0;
    end
    wait_idle();
    tick();
    check_frames("random");
    $display("random traffic: %0d frames", cap_q.size());

    check("sclk_edges_while_sync_high", idle_edges, 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
